// File: rtl/periph_interconnect.sv
// ---------------------------------------------------------------------------------------------
// periph_interconnect
//
// Single-master to N_SLAVES peripheral interconnect. Accepts one request at a time in IDLE,
// decodes the slave index from addr_i[31:24], drives a one-hot request to the selected slave
// while waiting for its ready, then returns a one-cycle ready_o pulse. The pulse carries the
// read data and an error flag. Requests to an index >= N_SLAVES answer straight away with an
// error and ERR_RDATA.
//
// Optional feature: define PERIPH_INTERCONNECT_TIMEOUT_EN to add a WAIT timeout. After
// TIMEOUT_CYCLES WAIT cycles without slave ready, the block answers with an error. Without
// the macro, WAIT lasts until the selected slave is ready.
//
// Parameters
//   N_SLAVES       number of slave channels (1..256)
//   TIMEOUT_CYCLES WAIT cycles before an error response (1..65535, timeout build only)
//   ERR_RDATA      read data returned with an error response
//
// Ports
//   clk_i, resetn_i           clock, asynchronous active-low reset
//   req_i, we_i, be_i         master request, write enable and byte enables
//   addr_i, wd_i              master address and write data
//   rd_o, ready_o, err_o      response data, one-cycle response pulse, error flag
//   slv_req_o                 one-hot slave request (only in WAIT)
//   slv_we_o, slv_be_o        registered write enable and byte enables
//   slv_addr_o, slv_wd_o      registered address (bits [31:24] cleared) and write data
//   slv_rd_i                  packed slave read data, slave k at [32k+31:32k]
//   slv_ready_i               per-slave ready
// ---------------------------------------------------------------------------------------------
module periph_interconnect #(
   parameter int unsigned N_SLAVES       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                     clk_i,
   input  logic                     resetn_i,
   input  logic                     req_i,
   input  logic                     we_i,
   input  logic [3:0]               be_i,
   input  logic [31:0]              addr_i,
   input  logic [31:0]              wd_i,
   output logic [31:0]              rd_o,
   output logic                     ready_o,
   output logic                     err_o,
   output logic [N_SLAVES-1:0]      slv_req_o,
   output logic                     slv_we_o,
   output logic [3:0]               slv_be_o,
   output logic [31:0]              slv_addr_o,
   output logic [31:0]              slv_wd_o,
   input  logic [32*N_SLAVES-1:0]   slv_rd_i,
   input  logic [N_SLAVES-1:0]      slv_ready_i
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                state_q;
   logic [7:0]            idx_q;
   logic [31:0]           rd_q;
   logic                  ready_q;
   logic                  err_q;
   logic [N_SLAVES-1:0]   slv_req_q;
   logic                  we_q;
   logic [3:0]            be_q;
   logic [31:0]           addr_q;
   logic [31:0]           wd_q;

   // Decode of the incoming request
   logic [7:0]            req_idx;
   logic                  req_mapped;
   logic [N_SLAVES-1:0]   req_onehot;

   // Response of the latched slave; other slaves' ready bits never reach the FSM
   logic                  sel_ready;
   logic [31:0]           sel_rd;

   logic                  tmo_hit;

   assign req_idx    = addr_i[31:24];
   assign req_mapped = (32'(req_idx) < N_SLAVES);

   always_comb begin
      req_onehot = '0;
      sel_ready  = 1'b0;
      sel_rd     = '0;
      for (int unsigned k = 0; k < N_SLAVES; k++) begin
         if (req_idx == 8'(k)) begin
            req_onehot[k] = 1'b1;
         end
         if (idx_q == 8'(k)) begin
            sel_ready = slv_ready_i[k];
            sel_rd    = slv_rd_i[32*k +: 32];
         end
      end
   end

`ifdef PERIPH_INTERCONNECT_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;

   // Held at 0 in IDLE so it starts from 0 on entry to WAIT; counts each WAIT cycle.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         tmo_cnt_q <= '0;
      end else if (state_q == StIdle) begin
         tmo_cnt_q <= '0;
      end else if (state_q == StWait) begin
         tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
   end

   // Fires in the TIMEOUT_CYCLES-th WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES cycles.
   assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo_cfg;

   assign tmo_hit        = 1'b0;
   assign unused_tmo_cfg = ^16'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         rd_q      <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         slv_req_q <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               if (req_i) begin
                  idx_q  <= req_idx;
                  we_q   <= we_i;
                  be_q   <= be_i;
                  addr_q <= {8'h00, addr_i[23:0]};
                  wd_q   <= wd_i;
                  if (req_mapped) begin
                     slv_req_q <= req_onehot;
                     state_q   <= StWait;
                  end else begin
                     // Unmapped: answer in the next cycle without touching any slave
                     rd_q    <= ERR_RDATA;
                     ready_q <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= StResp;
                  end
               end
            end

            StWait: begin
               // Slave ready takes priority over a timeout in the same cycle
               if (sel_ready) begin
                  slv_req_q <= '0;
                  rd_q      <= sel_rd;
                  ready_q   <= 1'b1;
                  err_q     <= 1'b0;
                  state_q   <= StResp;
               end else if (tmo_hit) begin
                  slv_req_q <= '0;
                  rd_q      <= ERR_RDATA;
                  ready_q   <= 1'b1;
                  err_q     <= 1'b1;
                  state_q   <= StResp;
               end
            end

            StResp: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               slv_req_q <= '0;
               ready_q   <= 1'b0;
               err_q     <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

   assign rd_o       = rd_q;
   assign ready_o    = ready_q;
   assign err_o      = err_q;
   assign slv_req_o  = slv_req_q;
   assign slv_we_o   = we_q;
   assign slv_be_o   = be_q;
   assign slv_addr_o = addr_q;
   assign slv_wd_o   = wd_q;

endmodule

// File: tb/tb_periph_interconnect.sv
// ---------------------------------------------------------------------------------------------
// tb_periph_interconnect
//
// Self-checking bench for periph_interconnect (N_SLAVES=8, TIMEOUT_CYCLES=4). Directed steps
// cover reset, request-during-reset, minimum-latency read, multi-cycle write, unmapped access,
// ignored foreign ready, timeout (or its absence) and reset mid-WAIT. These are followed by
// random transactions. Expected values come from a transaction-level model: latency, request
// cycles and response data follow from the slave index and the slave's ready delay.
// Honours PERIPH_INTERCONNECT_TIMEOUT_EN the same way as the design.
// ---------------------------------------------------------------------------------------------
module tb_periph_interconnect;

   localparam int unsigned NS  = 8;
   localparam int unsigned TMO = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic               clk;
   logic               resetn;
   logic               req;
   logic               we;
   logic [3:0]         be;
   logic [31:0]        addr;
   logic [31:0]        wd;
   logic [31:0]        rd_o;
   logic               ready_o;
   logic               err_o;
   logic [NS-1:0]      slv_req_o;
   logic               slv_we_o;
   logic [3:0]         slv_be_o;
   logic [31:0]        slv_addr_o;
   logic [31:0]        slv_wd_o;
   logic [32*NS-1:0]   slv_rd;
   logic [NS-1:0]      slv_ready;

   logic [31:0]        slave_data [NS];
   logic [31:0]        last_rd;
   int                 total = 0;
   int                 bad   = 0;

   periph_interconnect #(
      .N_SLAVES       (NS),
      .TIMEOUT_CYCLES (TMO),
      .ERR_RDATA      (ERR)
   ) dut (
      .clk_i       (clk),
      .resetn_i    (resetn),
      .req_i       (req),
      .we_i        (we),
      .be_i        (be),
      .addr_i      (addr),
      .wd_i        (wd),
      .rd_o        (rd_o),
      .ready_o     (ready_o),
      .err_o       (err_o),
      .slv_req_o   (slv_req_o),
      .slv_we_o    (slv_we_o),
      .slv_be_o    (slv_be_o),
      .slv_addr_o  (slv_addr_o),
      .slv_wd_o    (slv_wd_o),
      .slv_rd_i    (slv_rd),
      .slv_ready_i (slv_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      slv_rd = '0;
      for (int k = 0; k < NS; k++) slv_rd[32*k +: 32] = slave_data[k];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd"}, rd_o, 32'h0);
      check({tag, "_ready"}, 32'(ready_o), 32'h0);
      check({tag, "_err"}, 32'(err_o), 32'h0);
      check({tag, "_slv_req"}, 32'(slv_req_o), 32'h0);
      check({tag, "_slv_we"}, 32'(slv_we_o), 32'h0);
      check({tag, "_slv_be"}, 32'(slv_be_o), 32'h0);
      check({tag, "_slv_addr"}, slv_addr_o, 32'h0);
      check({tag, "_slv_wd"}, slv_wd_o, 32'h0);
   endtask

   // One transaction. The selected slave asserts ready once it has seen `delay` request
   // cycles (never, if `never` is set). Every other slave's ready is random, plus `force_rdy`.
   task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input int delay, input logic [NS-1:0] force_rdy,
                          input bit never);
      int            idx;
      bit            mapped;
      logic [NS-1:0] tgt;
      int            exp_lat;
      int            exp_reqc;
      logic [31:0]   exp_rd;
      logic          exp_err;
      int            waitc;
      int            lat;
      int            reqc;
      idx      = int'(a[31:24]);
      mapped   = (idx < NS);
      tgt      = mapped ? (NS'(1) << idx) : '0;
      exp_lat  = mapped ? delay + 2 : 1;
      exp_reqc = mapped ? delay + 1 : 0;
      exp_rd   = mapped ? slave_data[idx] : ERR;
      exp_err  = !mapped;
      if (mapped && never) begin
         exp_lat  = TMO + 1;
         exp_reqc = TMO;
         exp_rd   = ERR;
         exp_err  = 1'b1;
      end
      waitc = 0;
      lat   = 0;
      reqc  = 0;

      @(negedge clk);
      req       = 1'b1;
      we        = w;
      be        = b;
      addr      = a;
      wd        = d;
      slv_ready = (NS'($urandom) & ~tgt) | force_rdy;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (slv_req_o != '0) begin
            reqc++;
            waitc++;
            check("slv_req_onehot", 32'(slv_req_o), 32'(tgt));
         end
         if (ready_o) begin
            lat = c;
            break;
         end
         check("err_without_ready", 32'(err_o), 32'h0);
         check("rd_hold_waiting", rd_o, last_rd);
         slv_ready = (NS'($urandom) & ~tgt) | force_rdy;
         if (!never && waitc > delay) slv_ready = slv_ready | tgt;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("req_cycles", 32'(reqc), 32'(exp_reqc));
      check("resp_err", 32'(err_o), 32'(exp_err));
      check("resp_rd", rd_o, exp_rd);
      check("resp_slv_req_clear", 32'(slv_req_o), 32'h0);
      check("slv_addr", slv_addr_o, {8'h00, a[23:0]});
      check("slv_we", 32'(slv_we_o), 32'(w));
      check("slv_be", 32'(slv_be_o), 32'(b));
      check("slv_wd", slv_wd_o, d);
      last_rd   = exp_rd;
      req       = 1'b0;
      slv_ready = '0;
      @(negedge clk);
      check("ready_single_pulse", 32'(ready_o), 32'h0);
      check("err_after_resp", 32'(err_o), 32'h0);
      check("rd_hold_after", rd_o, last_rd);
   endtask

   initial begin
      int ready_cnt;
      int hold;
      logic [31:0] ra;
      resetn    = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      be        = '0;
      addr      = '0;
      wd        = '0;
      slv_ready = '0;
      last_rd   = '0;
      for (int k = 0; k < NS; k++) slave_data[k] = $urandom;

      // Reset state, with an unmapped request already held on req
      #3;
      check_all_zero("reset");
      req  = 1'b1;
      addr = 32'h0900_0000;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_accept_ready", 32'(ready_o), 32'h1);
      check("post_reset_accept_err", 32'(err_o), 32'h1);
      check("post_reset_accept_rd", rd_o, ERR);
      last_rd = ERR;
      req     = 1'b0;
      @(negedge clk);
      check("post_reset_ready_low", 32'(ready_o), 32'h0);

      // Minimum-latency read from slave 3
      slave_data[3] = 32'h1234_5678;
      run_txn(32'h0300_0010, 1'b0, 4'hF, 32'h0, 0, '0, 1'b0);

      // Write to slave 7, ready after 3 wait cycles
      run_txn(32'h0700_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 3, '0, 1'b0);

      // Unmapped index
      run_txn(32'h0900_0000, 1'b0, 4'hF, 32'h0, 0, '0, 1'b0);

      // Slave 2 selected while slave 5 keeps asserting ready
      run_txn(32'h0200_0000, 1'b0, 4'hF, 32'h0, 2, NS'(8'h20), 1'b0);

`ifdef PERIPH_INTERCONNECT_TIMEOUT_EN
      // Slave never ready: error after TMO wait cycles
      run_txn(32'h0400_0008, 1'b0, 4'hF, 32'h0, 0, '0, 1'b1);
      hold = 2;
`else
      hold = 1000;
`endif

      // Request stuck in WAIT; without timeout no ready may ever appear
      @(negedge clk);
      req       = 1'b1;
      we        = 1'b1;
      be        = 4'hC;
      addr      = 32'h0100_0040;
      wd        = 32'h0BAD_F00D;
      slv_ready = '0;
      ready_cnt = 0;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         if (ready_o) ready_cnt++;
      end
      check("no_ready_while_waiting", 32'(ready_cnt), 32'h0);
      check("stuck_slv_req", 32'(slv_req_o), 32'h2);
      #2;
      resetn = 1'b0;
      req    = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      check("reset_no_ready", 32'(ready_o), 32'h0);
      check("reset_slv_req", 32'(slv_req_o), 32'h0);
      resetn  = 1'b1;
      last_rd = '0;
      run_txn(32'h0600_0100, 1'b0, 4'h1, 32'h0, 1, '0, 1'b0);

      // Random traffic
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < NS; k++) slave_data[k] = $urandom;
         ra = {8'($urandom_range(0, 9)), 24'($urandom)};
         run_txn(ra, 1'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 4)), '0,
                 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/periph_interconnect.md
PERIPH_INTERCONNECT -- requirements
Module: periph_interconnect

Interface
REQ-001 The block SHALL have parameter N_SLAVES, default 8, number of slave channels (1..256).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before an error response (1..65535).
REQ-003 The block SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on error.
REQ-004 clk_i  input  1  single system clock; all state on its rising edge.
REQ-005 resetn_i  input  1  reset, asynchronous, active-low.
REQ-006 req_i / we_i  input  1 / 1  master request and write enable; held stable by the master until ready_o.
REQ-007 be_i  input  4  master byte enables.
REQ-008 addr_i / wd_i  input  32 / 32  master address and write data.
REQ-009 rd_o  output  32  read data returned to the master.
REQ-010 ready_o / err_o  output  1 / 1  one-cycle response pulse and error flag.
REQ-011 slv_req_o  output  N_SLAVES  one-hot slave request.
REQ-012 slv_we_o / slv_be_o  output  1 / 4  registered copies of we_i and be_i.
REQ-013 slv_addr_o / slv_wd_o  output  32 / 32  registered address with bits [31:24] forced to 0, and registered write data.
REQ-014 slv_rd_i  input  32*N_SLAVES  packed slave read data; slave k occupies bits [32k+31:32k].
REQ-015 slv_ready_i  input  N_SLAVES  per-slave ready.

Function
REQ-016 Slave index SHALL be addr_i[31:24]; index >= N_SLAVES SHALL be unmapped.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP.
REQ-018 IDLE with req_i=1 SHALL latch index, we, be, addr and wd; next state WAIT if mapped, RESP with error if unmapped.
REQ-019 In WAIT, slv_req_o[index] SHALL be 1 and all other bits 0; in other states slv_req_o SHALL be all 0.
REQ-020 In WAIT with slv_ready_i[index]=1, the block SHALL capture slv_rd_i of that slave into rd_o and go to RESP with no error.
REQ-021 slv_ready_i bits of non-selected slaves SHALL be ignored.
REQ-022 RESP SHALL assert ready_o=1 for exactly one cycle, with err_o valid in that same cycle, then go to IDLE.
REQ-023 req_i SHALL be ignored in WAIT and RESP; a new request is accepted in IDLE no earlier than the cycle after RESP.
REQ-024 Minimum latency: req_i accepted at cycle 0, slv_req_o high at cycle 1, slave ready at cycle 1, ready_o at cycle 2.
REQ-025 An unmapped request SHALL give ready_o=1, err_o=1 and rd_o=ERR_RDATA at cycle 1, with no slv_req_o pulse.
REQ-026 rd_o SHALL hold its last value between responses.
REQ-027 err_o SHALL be 0 whenever ready_o is 0.
REQ-028 A write response SHALL still update rd_o with the slave's slv_rd_i.

Reset
REQ-029 On resetn_i=0 the block SHALL immediately enter IDLE with rd_o=0, ready_o=0, err_o=0, slv_req_o=0, slv_we_o=0, slv_be_o=0, slv_addr_o=0, slv_wd_o=0 and the timeout counter at 0.
REQ-030 Reset during WAIT SHALL abandon the transaction without any ready_o pulse.
REQ-031 After resetn_i is deasserted, a request held on req_i SHALL be accepted at the first rising edge.

Configuration
REQ-032 With macro PERIPH_INTERCONNECT_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-033 With the macro defined, when the counter reaches TIMEOUT_CYCLES without slave ready, the block SHALL go to RESP with err_o=1 and rd_o=ERR_RDATA.
REQ-034 With the macro defined, slave ready SHALL win when slave ready and timeout occur in the same cycle.
REQ-035 Without the macro, no counter SHALL exist and WAIT SHALL last indefinitely until slave ready.

Verification
REQ-036 N_SLAVES=8: read at addr 0x0300_0010, slave 3 ready in the same cycle, rd=0x1234_5678 -> slv_req_o=0x08 for one cycle, slv_addr_o=0x0000_0010, ready_o at cycle 2, rd_o=0x1234_5678, err_o=0.
REQ-037 Write at 0x0700_0004, we=1, be=4'b0011, wd=0xA5A5_A5A5, slave 7 ready after 3 wait cycles -> slv_req_o=0x80 held 4 cycles, slv_be_o=4'b0011, single ready_o pulse.
REQ-038 Request at 0x0900_0000 with N_SLAVES=8 -> ready_o=1, err_o=1, rd_o=0xDEAD_BEEF at cycle 1, slv_req_o never set.
REQ-039 Timeout macro on, TIMEOUT_CYCLES=4, slave never ready -> err_o=1 with ready_o after 4 WAIT cycles; timeout macro off -> no ready_o within 1000 cycles.
REQ-040 resetn_i low for one cycle mid-WAIT -> all outputs 0 asynchronously, no ready_o; the next request completes normally.
REQ-041 Slave 2 selected while slave 5 asserts slv_ready_i each cycle -> response waits for slave 2 only, and rd_o equals slave 2 data.
